// File: rtl/sdram_pro_burst_sched.sv
// sdram_pro_burst_sched: picks write/read SDRAM bursts from FIFO levels and keeps
// the SDRAM region as a burst-granular ring buffer with one burst in flight.
module sdram_pro_burst_sched #(
    parameter int          BURST_LEN   = 256,
    parameter logic [22:0] BASE_ADDR   = 23'd0,
    parameter int          BUF_BURSTS  = 16,
    parameter int          RFIFO_DEPTH = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        rd_enable,
    input  logic [9:0]  wfifo_rd_cnt,
    input  logic [10:0] rfifo_wr_cnt,
    output logic        sdram_wr_req,
    output logic [22:0] sdram_wr_addr,
    output logic [9:0]  WR_BURST_LEN,
    input  logic        sdram_wr_ack,
    output logic        sdram_rd_req,
    output logic [22:0] sdram_rd_addr,
    output logic [9:0]  RD_BURST_LEN,
    input  logic        sdram_rd_ack,
    output logic [7:0]  buf_level,
    output logic        wr_burst_done,
    output logic        rd_burst_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WR_RUN, RD_RUN, GAP} state_t;

    localparam logic [9:0]  BL        = 10'(BURST_LEN);
    localparam logic [7:0]  NB        = 8'(BUF_BURSTS);
    localparam logic [10:0] RD_LIMIT  = 11'(RFIFO_DEPTH - BURST_LEN);
    localparam logic [22:0] STEP      = 23'(BURST_LEN);
    localparam logic [22:0] LAST_SLOT = BASE_ADDR + 23'((BUF_BURSTS - 1) * BURST_LEN);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [22:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  level_q, level_d;
    logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
    logic        wr_done_q, wr_done_d, rd_done_q, rd_done_d;
    logic        last_wr_q, last_wr_d;
    logic        wr_ok, rd_ok;

    function automatic logic [22:0] next_ptr(input logic [22:0] p);
        return (p == LAST_SLOT) ? BASE_ADDR : p + STEP;
    endfunction

    assign wr_ok = init_end && wfifo_rd_cnt >= BL && level_q < NB;
    assign rd_ok = init_end && rd_enable && level_q != 8'd0 && rfifo_wr_cnt <= RD_LIMIT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                // round-robin on ties: the side not served last wins
                if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    state_d  = WR_RUN;
                    wr_req_d = 1'b1;
                end else if (rd_ok) begin
                    state_d  = RD_RUN;
                    rd_req_d = 1'b1;
                end
            end
            WR_RUN: if (sdram_wr_ack) begin
                wr_req_d = 1'b0;
                cnt_d    = cnt_q + 10'd1;
                if (cnt_q == BL - 10'd1) begin
                    wr_ptr_d  = next_ptr(wr_ptr_q);
                    level_d   = level_q + 8'd1;
                    wr_done_d = 1'b1;
                    last_wr_d = 1'b1;
                    state_d   = GAP;
                end
            end
            RD_RUN: if (sdram_rd_ack) begin
                rd_req_d = 1'b0;
                cnt_d    = cnt_q + 10'd1;
                if (cnt_q == BL - 10'd1) begin
                    rd_ptr_d  = next_ptr(rd_ptr_q);
                    level_d   = level_q - 8'd1;
                    rd_done_d = 1'b1;
                    last_wr_d = 1'b0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                cnt_d   = 10'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            wr_ptr_q  <= BASE_ADDR;
            rd_ptr_q  <= BASE_ADDR;
            level_q   <= 8'd0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign sdram_wr_req  = wr_req_q;
    assign sdram_rd_req  = rd_req_q;
    assign sdram_wr_addr = wr_ptr_q;
    assign sdram_rd_addr = rd_ptr_q;
    assign WR_BURST_LEN  = BL;
    assign RD_BURST_LEN  = BL;
    assign buf_level     = level_q;
    assign wr_burst_done = wr_done_q;
    assign rd_burst_done = rd_done_q;
    assign busy          = state_q != IDLE;

    // a write may only start with room in the ring, a read only with data in it
    a_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
        state_q == WR_RUN |-> level_q < NB);
    a_no_underflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
        state_q == RD_RUN |-> level_q != 8'd0);
endmodule
